// File: rtl/ahb3lite_wait_sram.sv
// AHB3-Lite slave SRAM with a programmable number of wait states per transfer.
// It gives a two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb3lite_wait_sram #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic [3:0]            cfg_wait,
  output logic [15:0]           xfer_cnt
);

  localparam int unsigned NB = HDATA_SIZE / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state, state_nxt, accept_dest;
  logic            accept, addr_err;
  logic [LB-1:0]   amask;
  logic [IW-1:0]   idx_r;
  logic [LB-1:0]   lane_r;
  logic            write_r;
  logic [2:0]      size_r;
  logic [3:0]      wait_cnt;
  logic [NB-1:0]   be;
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  assign accept = (state inside {S_IDLE, S_DATA, S_ERR2}) & HSEL & HREADY & HTRANS[1];

  always_comb begin
    amask = '0;
    for (int unsigned i = 0; i < LB; i++)
      if (i < 32'(HSIZE)) amask[i] = 1'b1;
    addr_err = ((HADDR >> LB) >= HADDR_SIZE'(MEM_DEPTH)) ||
               (32'(HSIZE) > LB) ||
               ((HADDR[LB-1:0] & amask) != '0);
    if (addr_err)            accept_dest = S_ERR1;
    else if (cfg_wait == '0) accept_dest = S_DATA;
    else                     accept_dest = S_WAIT;
  end

  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = accept_dest;
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt <= 4'd1) state_nxt = S_DATA;
      end
      S_DATA: state_nxt = accept ? accept_dest : S_IDLE;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        HRESP     = 1'b1;
        state_nxt = accept ? accept_dest : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    HRDATA = '0;
    if (state == S_DATA && !write_r) HRDATA = mem[idx_r];
  end

  // Lanes run from the low address bits for 2**size bytes; alignment was checked at acceptance.
  always_comb begin
    be = '0;
    for (int unsigned b = 0; b < NB; b++)
      be[b] = (b >= 32'(lane_r)) && (b < 32'(lane_r) + (32'd1 << size_r));
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= S_IDLE;
      xfer_cnt <= '0;
      idx_r    <= '0;
      lane_r   <= '0;
      write_r  <= 1'b0;
      size_r   <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_r    <= HADDR[LB +: IW];
        lane_r   <= HADDR[LB-1:0];
        write_r  <= HWRITE;
        size_r   <= HSIZE;
        wait_cnt <= cfg_wait;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == S_DATA && xfer_cnt != '1) xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

  // Memory has no reset; a reset edge still cancels a pending DATA-cycle write.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == S_DATA && write_r)
      for (int unsigned b = 0; b < NB; b++)
        if (be[b]) mem[idx_r][8*b +: 8] <= HWDATA[8*b +: 8];
  end

endmodule

// File: tb/tb_ahb3lite_wait_sram.sv
// Directed bench for ahb3lite_wait_sram: stalls, pipelining, byte lanes, errors and reset.
module tb_ahb3lite_wait_sram;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT, cfg_wait;
  logic [1:0]  HTRANS;
  logic [15:0] xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt = '0;

  assign HREADY = HREADYOUT;

  ahb3lite_wait_sram #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .cfg_wait(cfg_wait), .xfer_cnt(xfer_cnt)
  );

  always #5 HCLK = ~HCLK;

  // Single non-pipelined transfer; inputs change and outputs are sampled on falling edges.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [3:0] cw, input logic [3:0] cw_after,
                         output logic [31:0] rdata, output int stalls, output logic resp,
                         output logic stall_resp, output logic timeout);
    stalls = 0; stall_resp = 1'b0; timeout = 1'b1; rdata = '0; resp = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size; cfg_wait = cw;
    @(negedge HCLK);
    HTRANS = 2'b00; HWDATA = wdata; cfg_wait = cw_after;
    for (int i = 0; i < 32; i++) begin
      if (HREADYOUT) begin
        rdata = HRDATA; resp = HRESP; timeout = 1'b0;
        break;
      end
      stalls++;
      stall_resp |= HRESP;
      @(negedge HCLK);
    end
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
    HSIZE = 3'd2; HBURST = '0; HPROT = '0; cfg_wait = '0;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", HREADYOUT); end
    n_checks++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b expected 0", HRESP); end
    n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", HRDATA); end
    n_checks++; if (xfer_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", xfer_cnt); end
    HSEL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      HTRANS = (i % 2 == 1) ? 2'b01 : 2'b00;
      @(negedge HCLK);
      n_checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0)
        begin n_fail++; $display("FAIL idle_ready_resp[%0d]: got %b/%b expected 1/0", i, HREADYOUT, HRESP); end
      n_checks++; if (xfer_cnt !== 16'h0) begin n_fail++; $display("FAIL idle_cnt[%0d]: got %0d expected 0", i, xfer_cnt); end
    end
    HTRANS = 2'b00;
  endtask

  task automatic test_back_to_back();
    cfg_wait = 4'd0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = 3'd2;
    @(negedge HCLK);
    n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL b2b_write_ready: got %b expected 1", HREADYOUT); end
    HWDATA = 32'hDEADBEEF; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h10;
    @(negedge HCLK);
    HTRANS = 2'b00;
    n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL b2b_read_ready: got %b expected 1", HREADYOUT); end
    n_checks++; if (HRDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rdata: got %h expected deadbeef", HRDATA); end
    @(negedge HCLK);
    exp_cnt = exp_cnt + 16'd2;
    n_checks++; if (xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected %0d", xfer_cnt, exp_cnt); end
    n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL b2b_rdata_idle: got %h expected 0", HRDATA); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int st; logic rsp, srsp, to;
    do_xfer(1'b1, 32'h0, 3'd2, 32'hCAFEF00D, 4'd0, 4'd0, rd, st, rsp, srsp, to);
    n_checks++; if (st !== 0 || to) begin n_fail++; $display("FAIL wait0_stalls: got %0d expected 0", st); end
    // cfg_wait raised to 9 right after acceptance must not lengthen the stall
    do_xfer(1'b0, 32'h0, 3'd2, 32'h0, 4'd3, 4'd9, rd, st, rsp, srsp, to);
    n_checks++; if (st !== 3 || to) begin n_fail++; $display("FAIL wait3_stalls: got %0d expected 3", st); end
    n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wait3_rdata: got %h expected cafef00d", rd); end
    n_checks++; if (rsp !== 1'b0 || srsp !== 1'b0) begin n_fail++; $display("FAIL wait3_resp: got %b/%b expected 0/0", srsp, rsp); end
    do_xfer(1'b1, 32'h4, 3'd2, 32'h01020304, 4'd1, 4'd1, rd, st, rsp, srsp, to);
    n_checks++; if (st !== 1 || to) begin n_fail++; $display("FAIL wait1_write_stalls: got %0d expected 1", st); end
    exp_cnt = exp_cnt + 16'd3;
    n_checks++; if (xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL wait_cnt: got %0d expected %0d", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int st; logic rsp, srsp, to;
    do_xfer(1'b1, 32'h20, 3'd2, 32'h11223344, 4'd0, 4'd0, rd, st, rsp, srsp, to);
    do_xfer(1'b1, 32'h21, 3'd0, 32'hFFFFAAFF, 4'd0, 4'd0, rd, st, rsp, srsp, to);
    n_checks++; if (rsp !== 1'b0 || to) begin n_fail++; $display("FAIL byte_write_resp: got %b expected 0", rsp); end
    do_xfer(1'b0, 32'h20, 3'd2, 32'h0, 4'd0, 4'd0, rd, st, rsp, srsp, to);
    n_checks++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL byte_lane_rdata: got %h expected 1122aa44", rd); end
    do_xfer(1'b1, 32'h22, 3'd1, 32'hBEEF1234, 4'd2, 4'd2, rd, st, rsp, srsp, to);
    do_xfer(1'b0, 32'h20, 3'd2, 32'h0, 4'd0, 4'd0, rd, st, rsp, srsp, to);
    n_checks++; if (rd !== 32'hBEEFAA44) begin n_fail++; $display("FAIL half_lane_rdata: got %h expected beefaa44", rd); end
    exp_cnt = exp_cnt + 16'd5;
    n_checks++; if (xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL lanes_cnt: got %0d expected %0d", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_error();
    logic [31:0] rd; int st; logic rsp, srsp, to;
    logic [31:0] addrs [3];
    logic [2:0]  sizes [3];
    addrs[0] = 32'h400; sizes[0] = 3'd2;
    addrs[1] = 32'h1;   sizes[1] = 3'd1;
    addrs[2] = 32'h8;   sizes[2] = 3'd3;
    for (int i = 0; i < 3; i++) begin
      do_xfer(1'b0, addrs[i], sizes[i], 32'h0, 4'd2, 4'd2, rd, st, rsp, srsp, to);
      n_checks++; if (st !== 1 || srsp !== 1'b1 || to)
        begin n_fail++; $display("FAIL err_first[%0d]: got stalls %0d resp %b expected 1/1", i, st, srsp); end
      n_checks++; if (rsp !== 1'b1) begin n_fail++; $display("FAIL err_second[%0d]: got %b expected 1", i, rsp); end
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_rdata[%0d]: got %h expected 0", i, rd); end
    end
    n_checks++; if (xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL err_cnt: got %0d expected %0d", xfer_cnt, exp_cnt); end
    n_checks++; if (HRESP !== 1'b0 || HREADYOUT !== 1'b1)
      begin n_fail++; $display("FAIL err_recover: got %b/%b expected 1/0", HREADYOUT, HRESP); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; int st; logic rsp, srsp, to;
    do_xfer(1'b1, 32'h30, 3'd2, 32'h12345678, 4'd0, 4'd0, rd, st, rsp, srsp, to);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h30; HSIZE = 3'd2; cfg_wait = 4'd5;
    @(negedge HCLK);
    HTRANS = 2'b00; HWDATA = 32'h0BADF00D;
    n_checks++; if (HREADYOUT !== 1'b0) begin n_fail++; $display("FAIL rst_in_wait: got %b expected 0", HREADYOUT); end
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    n_checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0)
      begin n_fail++; $display("FAIL rst_outputs: got %b/%b expected 1/0", HREADYOUT, HRESP); end
    exp_cnt = '0;
    repeat (6) @(negedge HCLK);
    n_checks++; if (xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", xfer_cnt); end
    do_xfer(1'b0, 32'h30, 3'd2, 32'h0, 4'd0, 4'd0, rd, st, rsp, srsp, to);
    n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rst_mem: got %h expected 12345678", rd); end
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (xfer_cnt !== exp_cnt) begin n_fail++; $display("FAIL rst_cnt_after: got %0d expected %0d", xfer_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_error();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
